// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for a 5-stage RV32 core: per-stage load enables/bubbles from mem wait, mul/div, branch, load-use.
// Controls are combinational (same cycle); only FSM state, mul/div counter and stall counter are registered.
module pipe_hazard_ctrl #(
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             ex_md_start,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {RUN, MD_BUSY} state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic               mem_stall;
    logic               lu_haz;

    assign mem_stall = mem_req & ~mem_ready;
    assign lu_haz    = ex_mem_read & (ex_rd != 5'd0) &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_en    = 1'b1;
        md_done     = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;

        if (!rst_n) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
        end else if (state_q == RUN) begin
            if (mem_stall) begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            end else if (ex_md_start) begin
                {pc_en, ifid_en, idex_en} = 3'b000;
                exmem_flush = 1'b1;
                cnt_d       = 8'(MD_LAT - 1);
                state_d     = MD_BUSY;
            end else if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (lu_haz) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end else begin
            // The counter keeps running through a mem freeze except on the final cycle,
            // so md_done is deferred rather than lost.
            if (cnt_q > 8'd1) begin
                cnt_d = cnt_q - 8'd1;
                if (mem_stall) begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
                end else begin
                    {pc_en, ifid_en, idex_en} = 3'b000;
                    exmem_flush = 1'b1;
                end
            end else if (mem_stall) begin
                {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            end else begin
                md_done = 1'b1;
                state_d = RUN;
                cnt_d   = 8'd0;
                if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
            end
        end
    end

    assign md_busy   = (state_q == MD_BUSY);
    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= 8'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MD_LAT=4 and a narrow stall counter so saturation is reachable.
module tb_pipe_hazard_ctrl;

    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, ex_md_start;
    logic          mem_req, mem_ready;
    logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic          exmem_en, exmem_flush, memwb_en, md_busy, md_done;
    logic [CW-1:0] stall_cnt;
    logic [9:0]    ctl;

    int checks   = 0;
    int failures = 0;

    // Bit order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en exmem_flush memwb_en md_busy md_done
    localparam logic [9:0] DEF   = 10'b1101010100;
    localparam logic [9:0] RST   = 10'b0010101000;
    localparam logic [9:0] FRZ   = 10'b0000000000;
    localparam logic [9:0] FRZ_B = 10'b0000000010;
    localparam logic [9:0] MDS   = 10'b0000011100;
    localparam logic [9:0] MDS_B = 10'b0000011110;
    localparam logic [9:0] DONE  = 10'b1101010111;
    localparam logic [9:0] LU    = 10'b0001110100;
    localparam logic [9:0] BR    = 10'b1111110100;

    assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                  exmem_en, exmem_flush, memwb_en, md_busy, md_done};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .ex_md_start(ex_md_start), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
        .exmem_flush(exmem_flush), .memwb_en(memwb_en), .md_busy(md_busy),
        .md_done(md_done), .stall_cnt(stall_cnt)
    );

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0;
        ex_branch_taken = 0; ex_md_start = 0; mem_req = 0; mem_ready = 0;
    endtask

    // Drive point: 1ns after the rising edge; sample point: the falling edge.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        checks++; if (ctl !== RST) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, RST); end
        checks++; if (stall_cnt !== 6'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (ctl !== DEF) begin failures++; $display("FAIL idle_ctl cyc=%0d got=%b exp=%b", i, ctl, DEF); end
            tick();
        end
        @(negedge clk);
        checks++; if (stall_cnt !== 6'd0) begin failures++; $display("FAIL idle_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_load_use();
        tick();
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        @(negedge clk);
        checks++; if (ctl !== LU) begin failures++; $display("FAIL lu_rs2 got=%b exp=%b", ctl, LU); end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++; if (ctl !== DEF) begin failures++; $display("FAIL lu_after got=%b exp=%b", ctl, DEF); end
        checks++; if (stall_cnt !== 6'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
        // rd=x0 never creates a hazard
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        #1;
        checks++; if (ctl !== DEF) begin failures++; $display("FAIL lu_x0 got=%b exp=%b", ctl, DEF); end
        // matching index but operand not read
        ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0;
        #1;
        checks++; if (ctl !== DEF) begin failures++; $display("FAIL lu_unused got=%b exp=%b", ctl, DEF); end
        id_use_rs1 = 1;
        #1;
        checks++; if (ctl !== LU) begin failures++; $display("FAIL lu_rs1 got=%b exp=%b", ctl, LU); end
        tick();
        clear_inputs();
    endtask

    task automatic test_muldiv();
        logic [9:0] exp_seq [4] = '{MDS, MDS_B, MDS_B, DONE};
        ex_md_start = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (ctl !== exp_seq[i]) begin failures++; $display("FAIL md_seq cyc=%0d got=%b exp=%b", i, ctl, exp_seq[i]); end
            tick();
        end
        ex_md_start = 0;
        @(negedge clk);
        checks++; if (ctl !== DEF) begin failures++; $display("FAIL md_after got=%b exp=%b", ctl, DEF); end
        checks++; if (stall_cnt !== 6'd5) begin failures++; $display("FAIL md_cnt got=%0d exp=5", stall_cnt); end
    endtask

    task automatic test_md_mem_stall();
        logic [9:0] exp_seq [7] = '{MDS, MDS_B, MDS_B, FRZ_B, FRZ_B, FRZ_B, DONE};
        tick();
        ex_md_start = 1;
        for (int i = 0; i < 7; i++) begin
            mem_req   = (i >= 3);
            mem_ready = (i == 6);
            @(negedge clk);
            checks++; if (ctl !== exp_seq[i]) begin failures++; $display("FAIL md_memwait cyc=%0d got=%b exp=%b", i, ctl, exp_seq[i]); end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        checks++; if (stall_cnt !== 6'd11) begin failures++; $display("FAIL md_memwait_cnt got=%0d exp=11", stall_cnt); end
        // A freeze while cnt>1 still consumes a cycle of the mul/div latency
        tick();
        ex_md_start = 1;
        for (int i = 0; i < 4; i++) begin
            mem_req = (i == 1);
            @(negedge clk);
            case (i)
                0: begin checks++; if (ctl !== MDS)   begin failures++; $display("FAIL md_frz0 got=%b exp=%b", ctl, MDS);   end end
                1: begin checks++; if (ctl !== FRZ_B) begin failures++; $display("FAIL md_frz1 got=%b exp=%b", ctl, FRZ_B); end end
                2: begin checks++; if (ctl !== MDS_B) begin failures++; $display("FAIL md_frz2 got=%b exp=%b", ctl, MDS_B); end end
                default: begin checks++; if (ctl !== DONE) begin failures++; $display("FAIL md_frz3 got=%b exp=%b", ctl, DONE); end end
            endcase
            tick();
        end
        clear_inputs();
        @(negedge clk);
        checks++; if (stall_cnt !== 6'd14) begin failures++; $display("FAIL md_frz_cnt got=%0d exp=14", stall_cnt); end
    endtask

    task automatic test_branch_lu();
        tick();
        ex_branch_taken = 1; ex_mem_read = 1; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 1;
        @(negedge clk);
        checks++; if (ctl !== BR) begin failures++; $display("FAIL br_over_lu got=%b exp=%b", ctl, BR); end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++; if (stall_cnt !== 6'd14) begin failures++; $display("FAIL br_cnt got=%0d exp=14", stall_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_seq [9] = '{FRZ, MDS, MDS_B, MDS_B, DONE, MDS, MDS_B, MDS_B, DONE};
        tick();
        ex_md_start = 1;
        for (int i = 0; i < 9; i++) begin
            mem_req = (i == 0);
            @(negedge clk);
            checks++; if (ctl !== exp_seq[i]) begin failures++; $display("FAIL b2b cyc=%0d got=%b exp=%b", i, ctl, exp_seq[i]); end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        checks++; if (ctl !== DEF) begin failures++; $display("FAIL b2b_after got=%b exp=%b", ctl, DEF); end
        checks++; if (stall_cnt !== 6'd21) begin failures++; $display("FAIL b2b_cnt got=%0d exp=21", stall_cnt); end
    endtask

    task automatic test_reset_mid_md();
        tick();
        ex_md_start = 1;
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++; if (ctl !== MDS_B) begin failures++; $display("FAIL rstmd_pre got=%b exp=%b", ctl, MDS_B); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ctl !== RST) begin failures++; $display("FAIL rstmd_ctl got=%b exp=%b", ctl, RST); end
        checks++; if (stall_cnt !== 6'd0) begin failures++; $display("FAIL rstmd_cnt got=%0d exp=0", stall_cnt); end
        tick();
        rst_n = 1'b1;
        ex_md_start = 0;
        @(negedge clk);
        checks++; if (ctl !== DEF) begin failures++; $display("FAIL rstmd_run got=%b exp=%b", ctl, DEF); end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 70; i++) tick();
        @(negedge clk);
        checks++; if (stall_cnt !== 6'd63) begin failures++; $display("FAIL sat_cnt got=%0d exp=63", stall_cnt); end
        tick();
        @(negedge clk);
        checks++; if (stall_cnt !== 6'd63) begin failures++; $display("FAIL sat_hold got=%0d exp=63", stall_cnt); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_muldiv();
        test_md_mem_stall();
        test_branch_lu();
        test_back_to_back();
        test_reset_mid_md();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
